// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer pixel writer family: default geometry, FSM encoding, pixel merge.
// Optional macro FB_PIXEL_WRITER_CLEAR_EN adds the CLEAR state to the encoding.
package fb_pkg;

  localparam int FB_WIDTH  = 96;
  localparam int FB_HEIGHT = 48;
  localparam int FB_BPP    = 12;
  localparam int FB_ADDR_W = 12;
  localparam int FB_RD_LAT = 1;

  localparam int WORD_W    = 2 * FB_BPP;
  localparam int HALF_ROWS = FB_HEIGHT / 2;
  localparam int FB_WORDS  = FB_WIDTH * FB_HEIGHT / 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3
`ifdef FB_PIXEL_WRITER_CLEAR_EN
    , ST_CLEAR = 3'd4
`endif
  } state_e;

  // Top-half pixels live in the upper field of a word, bottom-half pixels in the lower field.
  function automatic logic [WORD_W-1:0] merge_pixel(
    input logic [WORD_W-1:0] word,
    input logic [FB_BPP-1:0] pix,
    input logic              half
  );
    return half ? {word[WORD_W-1:FB_BPP], pix} : {pix, word[FB_BPP-1:0]};
  endfunction

endpackage

// File: rtl/fb_xy_counter.sv
// Raster x/y counters with start-of-frame load, wrap detection and framebuffer address/half mapping.
// Shared by the pixel writer and readback paths.
module fb_xy_counter
  import fb_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT,
  parameter int ADDR_W = FB_ADDR_W
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clr_i,
  input  logic                      sof_i,
  input  logic                      adv_i,
  output logic [$clog2(WIDTH)-1:0]  x_o,
  output logic [$clog2(HEIGHT)-1:0] y_o,
  output logic [ADDR_W-1:0]         addr_o,
  output logic                      half_o,
  output logic                      last_o
);

  localparam int X_W  = $clog2(WIDTH);
  localparam int Y_W  = $clog2(HEIGHT);
  localparam int HALF = HEIGHT / 2;

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [Y_W-1:0] row;
  logic           x_last;
  logic           y_last;

  assign x_last = (x_q == X_W'(WIDTH - 1));
  assign y_last = (y_q == Y_W'(HEIGHT - 1));

  always_comb begin
    // NOTE: defaults first so every path assigns x_d/y_d and no latch is inferred.
    x_d = x_q;
    y_d = y_q;
    if (clr_i || sof_i) begin
      x_d = '0;
      y_d = '0;
    end else if (adv_i) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // Rows in the bottom half fold onto the same words as the top half.
  assign half_o = (y_q >= Y_W'(HALF));
  assign row    = half_o ? (y_q - Y_W'(HALF)) : y_q;
  assign addr_o = ADDR_W'(32'(row) * 32'(WIDTH) + 32'(x_q));
  assign last_o = x_last && y_last;
  assign x_o    = x_q;
  assign y_o    = y_q;

endmodule

// File: rtl/fb_pixel_writer.sv
// Raster pixel stream to dual-port framebuffer writer using per-pixel read-modify-write on port A.
// Optional macro FB_PIXEL_WRITER_CLEAR_EN enables the i_clear full-frame clear state.
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT,
  parameter int BPP    = FB_BPP,
  parameter int ADDR_W = FB_ADDR_W,
  parameter int RD_LAT = FB_RD_LAT
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pix_valid,
  input  logic [BPP-1:0]     i_pix_data,
  input  logic               i_sof,
  output logic               o_pix_ready,
  input  logic               i_clear,
  output logic [ADDR_W-1:0]  o_addr,
  output logic               o_rd_en,
  input  logic [2*BPP-1:0]   i_rd_data,
  output logic [2*BPP-1:0]   o_wr_data,
  output logic               o_wr_en,
  output logic               o_frame_done,
  output logic               o_busy
);

  localparam int N_WORDS = WIDTH * HEIGHT / 2;
  localparam int LAT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e                      state_q, state_d;
  logic [BPP-1:0]              pix_q;
  logic [2*BPP-1:0]            merged_q;
  logic [LAT_W-1:0]            lat_q;
  logic                        wait_last;
  logic                        accept;
  logic                        clear_req;
  logic                        clear_done;
  logic [ADDR_W-1:0]           fb_addr;
  logic                        fb_half;
  logic                        frame_last;
  logic [$clog2(WIDTH)-1:0]    unused_x;
  logic [$clog2(HEIGHT)-1:0]   unused_y;

`ifdef FB_PIXEL_WRITER_CLEAR_EN
  logic [ADDR_W-1:0] clr_q;

  assign clear_req  = i_clear;
  assign clear_done = (state_q == ST_CLEAR) && (clr_q == ADDR_W'(N_WORDS - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || state_q != ST_CLEAR) clr_q <= '0;
    else                              clr_q <= clr_q + 1'b1;
  end
`else
  logic unused_clear;

  assign unused_clear = i_clear;
  assign clear_req    = 1'b0;
  assign clear_done   = 1'b0;
`endif

  // A pending clear outranks a waiting pixel, so ready drops in that cycle.
  assign accept    = (state_q == ST_IDLE) && !clear_req && i_pix_valid;
  assign wait_last = (lat_q == LAT_W'(RD_LAT - 1));

  fb_xy_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W)
  ) u_xy (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .clr_i  (clear_done),
    .sof_i  (accept && i_sof),
    .adv_i  (state_q == ST_WRITE),
    .x_o    (unused_x),
    .y_o    (unused_y),
    .addr_o (fb_addr),
    .half_o (fb_half),
    .last_o (frame_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
`ifdef FB_PIXEL_WRITER_CLEAR_EN
        if (i_clear) state_d = ST_CLEAR;
        else
`endif
        if (i_pix_valid) state_d = ST_READ;
      end
      ST_READ:  state_d = ST_WAIT;
      ST_WAIT:  if (wait_last) state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
`ifdef FB_PIXEL_WRITER_CLEAR_EN
      ST_CLEAR: if (clear_done) state_d = ST_IDLE;
`endif
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_pix_ready  = 1'b0;
    o_rd_en      = 1'b0;
    o_wr_en      = 1'b0;
    o_wr_data    = '0;
    o_frame_done = 1'b0;
    o_addr       = fb_addr;
    case (state_q)
      ST_IDLE:  o_pix_ready = !clear_req;
      ST_READ:  o_rd_en = 1'b1;
      ST_WRITE: begin
        o_wr_en      = 1'b1;
        o_wr_data    = merged_q;
        o_frame_done = frame_last;
      end
`ifdef FB_PIXEL_WRITER_CLEAR_EN
      ST_CLEAR: begin
        o_wr_en = 1'b1;
        o_addr  = clr_q;
      end
`endif
      default: ;
    endcase
  end

  assign o_busy = (state_q != ST_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pix_q    <= '0;
      merged_q <= '0;
      lat_q    <= '0;
    end else begin
      if (accept) pix_q <= i_pix_data;
      if (state_q == ST_READ) begin
        lat_q <= '0;
      end else if (state_q == ST_WAIT) begin
        lat_q <= lat_q + 1'b1;
        if (wait_last) merged_q <= merge_pixel(i_rd_data, pix_q, fb_half);
      end
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Scoreboard bench for fb_pixel_writer: RMW data/address, timing, frame wrap, sof restart, reset, clear.
module tb_fb_pixel_writer;

  localparam int W     = 96;
  localparam int H     = 48;
  localparam int WORDS = W * H / 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_valid = 1'b0;
  logic [11:0] pix_data = '0;
  logic        sof = 1'b0;
  logic        clear = 1'b0;
  logic        pix_ready, rd_en, wr_en, frame_done, busy;
  logic [11:0] addr;
  logic [23:0] rd_data, wr_data;

  always #5 clk = ~clk;

  fb_pixel_writer dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pix_valid  (pix_valid),
    .i_pix_data   (pix_data),
    .i_sof        (sof),
    .o_pix_ready  (pix_ready),
    .i_clear      (clear),
    .o_addr       (addr),
    .o_rd_en      (rd_en),
    .i_rd_data    (rd_data),
    .o_wr_data    (wr_data),
    .o_wr_en      (wr_en),
    .o_frame_done (frame_done),
    .o_busy       (busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Framebuffer model with one-cycle read latency
  logic [23:0] mem [0:4095];
  logic        mem_zero = 1'b1;
  logic        set_en = 1'b0;
  logic [11:0] set_addr = '0;
  logic [23:0] set_val = '0;

  always @(posedge clk) begin
    if (mem_zero) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
    end else begin
      if (set_en) mem[set_addr] <= set_val;
      if (wr_en)  mem[addr] <= wr_data;
    end
    if (rd_en) rd_data <= mem[addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [11:0] addr;
    logic [23:0] data;
    logic        done;
  } exp_t;

  exp_t        sb[$];
  logic [23:0] ref_mem [0:4095];
  int          rx = 0, ry = 0;
  int          acc_cyc = -100, last_acc = -1, rd_cyc = -100;
  int          done_cnt = 0, wr_cnt = 0;
  logic [11:0] last_wr_addr = '0;
  logic [23:0] last_wr_data = '0;
  logic        in_clear = 1'b0;

  always @(negedge clk) begin
    if (rd_en && wr_en)       check("rd_wr_overlap", 1, 0);
    if (frame_done && !wr_en) check("done_stray", 1, 0);
    if (frame_done) done_cnt <= done_cnt + 1;
    if (rd_en && !in_clear) begin
      check("rd_latency", cyc - acc_cyc, 1);
      if (sb.size() != 0) check("rd_addr", addr, sb[0].addr);
      rd_cyc <= cyc;
    end
    if (wr_en && !in_clear) begin
      check("wr_latency", cyc - rd_cyc, 2);
      if (sb.size() == 0) begin
        check("wr_unexpected", 1, 0);
      end else begin
        check("wr_addr", addr, sb[0].addr);
        check("wr_data", wr_data, sb[0].data);
        check("frame_done", frame_done, sb[0].done);
        sb.delete(0);
      end
      last_wr_addr <= addr;
      last_wr_data <= wr_data;
      wr_cnt       <= wr_cnt + 1;
    end
  end

  task automatic model_push(input logic [11:0] d, input logic s);
    int          a;
    logic        half;
    logic [23:0] w;
    if (s) begin
      rx = 0;
      ry = 0;
    end
    half = (ry >= H / 2);
    a    = (half ? ry - H / 2 : ry) * W + rx;
    w    = ref_mem[a];
    w    = half ? {w[23:12], d} : {d, w[11:0]};
    ref_mem[a] = w;
    sb.push_back('{addr: 12'(a), data: w, done: (rx == W - 1 && ry == H - 1)});
    rx++;
    if (rx == W) begin
      rx = 0;
      ry = (ry == H - 1) ? 0 : ry + 1;
    end
  endtask

  // Drives on a negedge, waits for ready, returns just after the accepting posedge.
  task automatic send_pixel(input logic [11:0] d, input logic s, input bit push);
    bit ok = 1'b0;
    @(negedge clk);
    pix_valid = 1'b1;
    pix_data  = d;
    sof       = s;
    for (int i = 0; i < 50; i++) begin
      if (pix_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check("accept_timeout", 0, 1);
      pix_valid = 1'b0;
      return;
    end
    if (last_acc >= 0) check("pix_period", cyc - last_acc, 4);
    last_acc = cyc;
    acc_cyc  = cyc;
    @(posedge clk);
    if (push) model_push(d, s);
  endtask

  task automatic idle();
    @(negedge clk);
    pix_valid = 1'b0;
    sof       = 1'b0;
    last_acc  = -1;
  endtask

  task automatic drain();
    int pend;
    for (int i = 0; i < 50; i++) begin
      if (!busy && sb.size() == 0) break;
      @(negedge clk);
    end
    pend = sb.size() + int'(busy);
    check("drain", pend, 0);
  endtask

  task automatic set_mem(input logic [11:0] a, input logic [23:0] v);
    @(negedge clk);
    set_en   = 1'b1;
    set_addr = a;
    set_val  = v;
    @(negedge clk);
    set_en      = 1'b0;
    ref_mem[a]  = v;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    rst      = 1'b0;
    mem_zero = 1'b0;
    check("rst_ready", pix_ready, 1);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_addr", addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_done", frame_done, 0);
    check("rst_busy", busy, 0);

    // Top-half RMW at (5,0)
    set_mem(12'd5, 24'h000123);
    send_pixel(12'(32'($urandom)), 1'b1, 1'b1);
    for (int i = 1; i < 5; i++) send_pixel(12'(32'($urandom)), 1'b0, 1'b1);
    send_pixel(12'hABC, 1'b0, 1'b1);
    idle();
    drain();
    check("t1_addr", last_wr_addr, 5);
    check("t1_data", last_wr_data, 24'hABC123);

    // Bottom-half RMW at (5,24) preserves the top pixel
    repeat (2303) send_pixel(12'(32'($urandom)), 1'b0, 1'b1);
    send_pixel(12'h456, 1'b0, 1'b1);
    idle();
    drain();
    check("t2_addr", last_wr_addr, 5);
    check("t2_data", last_wr_data, 24'hABC456);

    // Rest of the frame, streamed with valid held high
    repeat (2298) send_pixel(12'(32'($urandom)), 1'b0, 1'b1);
    idle();
    drain();
    check("frame_writes", wr_cnt, 4608);
    check("frame_done_cnt", done_cnt, 1);
    check("frame_last_addr", last_wr_addr, 2303);

    send_pixel(12'h9A5, 1'b0, 1'b1);
    idle();
    drain();
    check("wrap_addr", last_wr_addr, 0);
    check("wrap_data_hi", last_wr_data[23:12], 12'h9A5);

    // Mid-frame sof restart
    repeat (10) send_pixel(12'(32'($urandom)), 1'b0, 1'b1);
    send_pixel(12'h0F0, 1'b1, 1'b1);
    idle();
    drain();
    check("sof_addr", last_wr_addr, 0);
    check("sof_data_hi", last_wr_data[23:12], 12'h0F0);
    check("sof_no_done", done_cnt, 1);

    // Reset during WAIT abandons the RMW
    send_pixel(12'h777, 1'b0, 1'b0);
    @(negedge clk);
    check("rstw_read", rd_en, 1);
    @(negedge clk);
    rst       = 1'b1;
    pix_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rstw_wr_en", wr_en, 0);
    check("rstw_ready", pix_ready, 1);
    check("rstw_busy", busy, 0);
    check("rstw_addr", addr, 0);
    check("rstw_rd_en", rd_en, 0);
    rx = 0;
    ry = 0;
    last_acc = -1;
    send_pixel(12'h321, 1'b0, 1'b1);
    idle();
    drain();
    check("rstw_next_addr", last_wr_addr, 0);
    check("rstw_next_data", last_wr_data[23:12], 12'h321);

`ifdef FB_PIXEL_WRITER_CLEAR_EN
    @(negedge clk);
    clear    = 1'b1;
    in_clear = 1'b1;
    check("clr_req_ready", pix_ready, 0);
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      check("clr_wr_en", wr_en, 1);
      check("clr_addr", addr, i);
      check("clr_data", wr_data, 0);
      check("clr_ready", pix_ready, 0);
      check("clr_busy", busy, 1);
      @(negedge clk);
    end
    in_clear = 1'b0;
    check("clr_end_busy", busy, 0);
    check("clr_end_ready", pix_ready, 1);
    check("clr_end_wr_en", wr_en, 0);
    check("clr_no_done", done_cnt, 1);
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    rx = 0;
    ry = 0;
    send_pixel(12'hC3C, 1'b0, 1'b1);
    idle();
    drain();
    check("clr_next_addr", last_wr_addr, 0);
    check("clr_next_data", last_wr_data, 24'hC3C000);
`else
    @(negedge clk);
    clear = 1'b1;
    check("noclr_ready", pix_ready, 1);
    @(negedge clk);
    check("noclr_busy", busy, 0);
    check("noclr_wr_en", wr_en, 0);
    send_pixel(12'h5A5, 1'b0, 1'b1);
    idle();
    clear = 1'b0;
    drain();
    check("noclr_pix_data", last_wr_data[23:12], 12'h5A5);
`endif

    repeat (3) @(negedge clk);
    check("sb_leftover", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
